// File: rtl/reset_seq_pkg.sv
// Shared constants for the core reset sequencer: FSM state encodings, reset-cause codes
// and a counter-width helper.
package reset_seq_pkg;

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_LOCK_HOLD = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_STRETCH   = 2'd3;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_BTN  = 2'b10;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level input; clears to 0 on reset.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Core reset sequencer: holds the core in reset until PLL lock is stable, re-asserts it on
// lock loss or a debounced button press, and records the cause of the last reset.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_HOLD   = 1024,
    parameter int unsigned DEBOUNCE    = 65536,
    parameter int unsigned RST_STRETCH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       btn_n,
    output logic       core_rst,
    output logic       core_rst_n,
    output logic       ready,
    output logic [1:0] reset_cause,
    output logic [7:0] lock_lost_cnt
);

    localparam int unsigned CNT_MAX = (LOCK_HOLD > RST_STRETCH) ? LOCK_HOLD : RST_STRETCH;
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
    localparam int unsigned DB_W    = cnt_width(DEBOUNCE + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(LOCK_HOLD - 1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(RST_STRETCH - 1);
    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE - 1);

    logic             lock_s;
    logic             btn_s;
    logic             btn_press_c;

    logic             btn_db_q,   btn_db_d;
    logic [DB_W-1:0]  db_cnt_q,   db_cnt_d;
    logic             press_q,    press_d;
    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [1:0]       cause_q,    cause_d;
    logic [7:0]       lost_q,     lost_d;
    logic             core_rst_q, core_rst_d;
    logic             core_rst_n_q, core_rst_n_d;
    logic             ready_q,    ready_d;
    logic [7:0]       lost_inc_c;

    // Button is active-low at the pin; synchronize it as "pressed".
    assign btn_press_c = ~btn_n;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_btn (
        .clk (clk),
        .rst (rst),
        .d   (btn_press_c),
        .q   (btn_s)
    );

    // Debouncer: accept a new level only after DEBOUNCE consecutive differing cycles.
    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_s != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = btn_s;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        press_d = btn_db_d & ~btn_db_q;
    end

    assign lost_inc_c = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;

    // Sequencer FSM; lock loss outranks a button press in RUN and STRETCH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        lost_d  = lost_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_LOCK_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_LOCK_HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cause_d = CAUSE_LOCK;
                    lost_d  = lost_inc_c;
                end else if (press_q) begin
                    state_d = ST_STRETCH;
                    cnt_d   = '0;
                    cause_d = CAUSE_BTN;
                end
            end
            ST_STRETCH: begin
                if (cnt_q != STRETCH_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cause_d = CAUSE_LOCK;
                    lost_d  = lost_inc_c;
                end else if ((cnt_q == STRETCH_LAST) && !btn_db_q) begin
                    state_d = ST_LOCK_HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase
        core_rst_d   = (state_d != ST_RUN);
        core_rst_n_d = (state_d == ST_RUN);
        ready_d      = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db_q     <= 1'b0;
            db_cnt_q     <= '0;
            press_q      <= 1'b0;
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            cause_q      <= CAUSE_POR;
            lost_q       <= 8'd0;
            core_rst_q   <= 1'b1;
            core_rst_n_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            btn_db_q     <= btn_db_d;
            db_cnt_q     <= db_cnt_d;
            press_q      <= press_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cause_q      <= cause_d;
            lost_q       <= lost_d;
            core_rst_q   <= core_rst_d;
            core_rst_n_q <= core_rst_n_d;
            ready_q      <= ready_d;
        end
    end

    assign core_rst      = core_rst_q;
    assign core_rst_n    = core_rst_n_q;
    assign ready         = ready_q;
    assign reset_cause   = cause_q;
    assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed testbench for reset_seq with SYNC_STAGES=2, LOCK_HOLD=8, DEBOUNCE=4, RST_STRETCH=4.
module tb_reset_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pll_lock = 1'b0;
    logic       btn_n = 1'b1;
    logic       core_rst;
    logic       core_rst_n;
    logic       ready;
    logic [1:0] reset_cause;
    logic [7:0] lock_lost_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    reset_seq #(
        .SYNC_STAGES (2),
        .LOCK_HOLD   (8),
        .DEBOUNCE    (4),
        .RST_STRETCH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_lock      (pll_lock),
        .btn_n         (btn_n),
        .core_rst      (core_rst),
        .core_rst_n    (core_rst_n),
        .ready         (ready),
        .reset_cause   (reset_cause),
        .lock_lost_cnt (lock_lost_cnt)
    );

    always #5 clk = ~clk;

    // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after an edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until core_rst reaches level, or -1 if the budget runs out.
    task automatic wait_core_rst(input logic level, input int limit, output int edges);
        int i;
        i = 0;
        edges = -1;
        while (edges < 0 && i < limit) begin
            tick(1);
            i++;
            if (core_rst === level) edges = i;
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        pll_lock = 1'b0;
        btn_n = 1'b1;
        #1;
        n_checks++;
        if (core_rst !== 1'b1 || core_rst_n !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_outputs: core_rst=%b core_rst_n=%b ready=%b expected 1 0 0",
                     core_rst, core_rst_n, ready);
        end
        tick(3);
        n_checks++;
        if (reset_cause !== 2'b00 || lock_lost_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_cause_cnt: cause=%b cnt=%0d expected 00 0", reset_cause, lock_lost_cnt);
        end
        n_checks++;
        if (core_rst !== 1'b1 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: core_rst=%b ready=%b expected 1 0", core_rst, ready);
        end
    endtask

    task automatic test_power_up;
        int e;
        rst = 1'b0;
        tick(7);
        n_checks++;
        if (core_rst !== 1'b1 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL powerup_no_lock: core_rst=%b ready=%b expected 1 0", core_rst, ready);
        end
        pll_lock = 1'b1;
        wait_core_rst(1'b0, 40, e);
        n_checks++;
        if (e !== 11) begin
            n_fail++;
            $display("FAIL powerup_release_edges: got %0d expected 11", e);
        end
        n_checks++;
        if (ready !== 1'b1 || core_rst_n !== 1'b1 || reset_cause !== 2'b00) begin
            n_fail++;
            $display("FAIL powerup_run_outputs: ready=%b core_rst_n=%b cause=%b expected 1 1 00",
                     ready, core_rst_n, reset_cause);
        end
    endtask

    task automatic test_lock_glitch;
        int e;
        pll_lock = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        pll_lock = 1'b1;
        tick(5);
        pll_lock = 1'b0;
        tick(1);
        n_checks++;
        if (core_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_held_in_hold: core_rst=%b expected 1", core_rst);
        end
        pll_lock = 1'b1;
        wait_core_rst(1'b0, 40, e);
        n_checks++;
        if (e !== 11) begin
            n_fail++;
            $display("FAIL glitch_release_edges: got %0d expected 11", e);
        end
        n_checks++;
        if (lock_lost_cnt !== 8'd0 || reset_cause !== 2'b00) begin
            n_fail++;
            $display("FAIL glitch_no_loss: cnt=%0d cause=%b expected 0 00", lock_lost_cnt, reset_cause);
        end
    endtask

    task automatic test_lock_loss;
        int e;
        int e2;
        int timeouts;
        pll_lock = 1'b0;
        wait_core_rst(1'b1, 20, e);
        n_checks++;
        if (e !== 3) begin
            n_fail++;
            $display("FAIL loss_assert_edges: got %0d expected 3", e);
        end
        n_checks++;
        if (reset_cause !== 2'b01 || lock_lost_cnt !== 8'd1 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL loss_outputs: cause=%b cnt=%0d ready=%b expected 01 1 0",
                     reset_cause, lock_lost_cnt, ready);
        end
        pll_lock = 1'b1;
        wait_core_rst(1'b0, 40, e);
        n_checks++;
        if (e !== 11) begin
            n_fail++;
            $display("FAIL loss_regain_edges: got %0d expected 11", e);
        end
        n_checks++;
        if (reset_cause !== 2'b01 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_regain_outputs: cause=%b ready=%b expected 01 1", reset_cause, ready);
        end
        timeouts = 0;
        for (int k = 2; k <= 300; k++) begin
            pll_lock = 1'b0;
            wait_core_rst(1'b1, 20, e);
            pll_lock = 1'b1;
            wait_core_rst(1'b0, 40, e2);
            if (e < 0 || e2 < 0) timeouts++;
            if (k == 254) begin
                n_checks++;
                if (lock_lost_cnt !== 8'd254) begin
                    n_fail++;
                    $display("FAIL loss_count_254: got %0d expected 254", lock_lost_cnt);
                end
            end
        end
        n_checks++;
        if (timeouts !== 0) begin
            n_fail++;
            $display("FAIL loss_repeat_timeouts: got %0d expected 0", timeouts);
        end
        n_checks++;
        if (lock_lost_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL loss_count_saturate: got %0d expected 255", lock_lost_cnt);
        end
    endtask

    task automatic test_bouncy_button;
        int e;
        int low_seen;
        for (int i = 0; i < 10; i++) begin
            btn_n = ~btn_n;
            tick(2);
        end
        n_checks++;
        if (core_rst !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_ignored: core_rst=%b ready=%b expected 0 1", core_rst, ready);
        end
        btn_n = 1'b0;
        wait_core_rst(1'b1, 30, e);
        n_checks++;
        if (e !== 7) begin
            n_fail++;
            $display("FAIL button_assert_edges: got %0d expected 7", e);
        end
        n_checks++;
        if (reset_cause !== 2'b10 || lock_lost_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL button_cause: cause=%b cnt=%0d expected 10 255", reset_cause, lock_lost_cnt);
        end
        low_seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (core_rst !== 1'b1) low_seen++;
        end
        n_checks++;
        if (low_seen !== 0) begin
            n_fail++;
            $display("FAIL button_hold_keeps_reset: released cycles=%0d expected 0", low_seen);
        end
        btn_n = 1'b1;
        wait_core_rst(1'b0, 40, e);
        n_checks++;
        if (e !== 15) begin
            n_fail++;
            $display("FAIL button_release_edges: got %0d expected 15", e);
        end
        n_checks++;
        if (ready !== 1'b1 || reset_cause !== 2'b10) begin
            n_fail++;
            $display("FAIL button_release_outputs: ready=%b cause=%b expected 1 10", ready, reset_cause);
        end
    endtask

    task automatic test_simultaneous;
        int e;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        wait_core_rst(1'b0, 40, e);
        n_checks++;
        if (e !== 11 || lock_lost_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL sim_prep_release: edges=%0d cnt=%0d expected 11 0", e, lock_lost_cnt);
        end
        btn_n = 1'b0;
        tick(4);
        pll_lock = 1'b0;
        tick(2);
        n_checks++;
        if (core_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_before_edge: core_rst=%b expected 0", core_rst);
        end
        tick(1);
        n_checks++;
        if (core_rst !== 1'b1 || reset_cause !== 2'b01 || lock_lost_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL sim_lock_priority: core_rst=%b cause=%b cnt=%0d expected 1 01 1",
                     core_rst, reset_cause, lock_lost_cnt);
        end
        btn_n = 1'b1;
        pll_lock = 1'b1;
        wait_core_rst(1'b0, 40, e);
        n_checks++;
        if (e !== 11 || reset_cause !== 2'b01) begin
            n_fail++;
            $display("FAIL sim_recover: edges=%0d cause=%b expected 11 01", e, reset_cause);
        end
    endtask

    task automatic test_async_reset_stretch;
        int e;
        btn_n = 1'b0;
        wait_core_rst(1'b1, 30, e);
        n_checks++;
        if (e !== 7 || reset_cause !== 2'b10) begin
            n_fail++;
            $display("FAIL stretch_entry: edges=%0d cause=%b expected 7 10", e, reset_cause);
        end
        tick(2);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (core_rst !== 1'b1 || core_rst_n !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_outputs: core_rst=%b core_rst_n=%b ready=%b expected 1 0 0",
                     core_rst, core_rst_n, ready);
        end
        n_checks++;
        if (reset_cause !== 2'b00 || lock_lost_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL async_rst_status: cause=%b cnt=%0d expected 00 0", reset_cause, lock_lost_cnt);
        end
        btn_n = 1'b1;
        tick(2);
        rst = 1'b0;
        wait_core_rst(1'b0, 40, e);
        n_checks++;
        if (e !== 11 || reset_cause !== 2'b00) begin
            n_fail++;
            $display("FAIL async_rst_recover: edges=%0d cause=%b expected 11 00", e, reset_cause);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_glitch();
        test_lock_loss();
        test_bouncy_button();
        test_simultaneous();
        test_async_reset_stretch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
